// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared types for the BTB update path: word type, queued update
//            record and the update-controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W    = 32;
    // btb_upd_t.index width; the controller's IDX_W must equal this value.
    localparam int c_BTB_IDX_W = 2;

    typedef logic [c_WORD_W-1:0] word_t;

    typedef struct packed {
        logic [c_BTB_IDX_W-1:0] index;
        word_t                  target;
        logic                   taken;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } btb_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : btb_upd_fifo
// Brief    : Update queue for btb_update_ctrl. The storage array and read
//            pointer are exported only when BTB_UPD_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module btb_upd_fifo
    import cpu_types_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push_valid,
    input  btb_upd_t                    i_push_data,
    input  logic                        i_pop,
    output logic                        o_push,
    output logic                        o_ready,
    output btb_upd_t                    o_head,
`ifdef BTB_UPD_BYPASS_EN
    output btb_upd_t                    o_mem [QDEPTH],
    output logic [$clog2(QDEPTH)-1:0]   o_rd_ptr,
`endif
    output logic [$clog2(QDEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = $clog2(QDEPTH) + 1;

    btb_upd_t           r_mem_q [QDEPTH];
    btb_upd_t           w_mem_d [QDEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic               r_ready_q;
    logic               w_ready_d;
    logic               w_push;

    // Ready is a flop so a same-cycle pop can never re-open a full queue.
    assign w_push = i_push_valid && r_ready_q;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_push_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (i_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, i_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
        w_ready_d = (w_count_d != c_CNT_W'(QDEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_ready_q  <= w_ready_d;
        end
    end

    assign o_push  = w_push;
    assign o_ready = r_ready_q;
    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;
`ifdef BTB_UPD_BYPASS_EN
    assign o_mem    = r_mem_q;
    assign o_rd_ptr = r_rd_ptr_q;
`endif

endmodule
`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Brief    : Arbitrates the single BTB port between fetch lookups and queued
//            resolved-branch writes, with anti-starvation forced writes.
//            Define BTB_UPD_BYPASS_EN to forward pending updates to lookups.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl
    import cpu_types_pkg::*;
#(
    parameter int QDEPTH     = 4,
    parameter int IDX_W      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     fetch_req,
    input  logic [IDX_W-1:0]         fetch_index,
    output logic                     fetch_stall,
    input  logic                     res_valid,
    input  logic [IDX_W-1:0]         res_index,
    input  logic [c_WORD_W-1:0]      res_target,
    input  logic                     res_taken,
    output logic                     res_ready,
    output logic                     btb_ren,
    output logic [IDX_W-1:0]         btb_rindex,
    output logic                     btb_wen,
    output logic [IDX_W-1:0]         btb_windex,
    output logic [c_WORD_W-1:0]      btb_wtarget,
    output logic                     btb_wtaken,
    output logic                     fwd_hit,
    output logic [c_WORD_W-1:0]      fwd_target,
    output logic                     fwd_taken,
    output logic [$clog2(QDEPTH):0]  qcount
);

    localparam int                 c_PTR_W   = $clog2(QDEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam int                 c_STV_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_MAX);

    btb_ctrl_state_t    r_state_q;
    btb_ctrl_state_t    w_state_d;
    logic [c_STV_W-1:0] r_starve_q;
    logic [c_STV_W-1:0] w_starve_d;
    logic               w_wen;
    logic               w_stall;
    logic               w_push;
    logic               w_ready;
    logic               w_last;
    btb_upd_t           w_push_data;
    btb_upd_t           w_head;
    logic [c_CNT_W-1:0] w_count;
`ifdef BTB_UPD_BYPASS_EN
    btb_upd_t           w_mem [QDEPTH];
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_PTR_W-1:0] w_slot;
`endif

    assign w_push_data = '{index: res_index, target: res_target, taken: res_taken};

    btb_upd_fifo #(
        .QDEPTH       (QDEPTH)
    ) u_fifo (
        .clk          (CLK),
        .rst          (RST),
        .i_push_valid (res_valid),
        .i_push_data  (w_push_data),
        .i_pop        (w_wen),
        .o_push       (w_push),
        .o_ready      (w_ready),
        .o_head       (w_head),
`ifdef BTB_UPD_BYPASS_EN
        .o_mem        (w_mem),
        .o_rd_ptr     (w_rd_ptr),
`endif
        .o_count      (w_count)
    );

    // Popping the only entry with no refill empties the queue.
    assign w_last = (w_count == c_CNT_W'(1)) && !w_push;

    always_comb begin
        w_state_d  = r_state_q;
        w_starve_d = '0;
        w_wen      = 1'b0;
        w_stall    = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_push) begin
                    w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!fetch_req) begin
                    w_wen = 1'b1;
                    if (w_last) begin
                        w_state_d = IDLE;
                    end
                end else begin
                    if (r_starve_q != c_STV_MAX) begin
                        w_starve_d = r_starve_q + 1'b1;
                    end else begin
                        w_starve_d = r_starve_q;
                    end
                    if (w_starve_d == c_STV_MAX) begin
                        w_state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                w_wen     = 1'b1;
                w_stall   = 1'b1;
                w_state_d = w_last ? IDLE : DRAIN;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q  <= IDLE;
            r_starve_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_starve_q <= w_starve_d;
        end
    end

    // RST gates the read strobe so a lookup cannot escape while held in reset.
    assign btb_ren     = fetch_req && !w_stall && !RST;
    assign btb_rindex  = fetch_index;
    assign btb_wen     = w_wen;
    assign fetch_stall = w_stall;
    assign res_ready   = w_ready;
    assign qcount      = w_count;
    assign btb_windex  = w_head.index;
    assign btb_wtarget = w_head.target;
    assign btb_wtaken  = w_head.taken;

`ifdef BTB_UPD_BYPASS_EN
    // Walk oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        fwd_hit    = 1'b0;
        fwd_target = '0;
        fwd_taken  = 1'b0;
        w_slot     = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            w_slot = w_rd_ptr + c_PTR_W'(k);
            if (fetch_req && (c_CNT_W'(k) < w_count) &&
                (w_mem[w_slot].index == fetch_index)) begin
                fwd_hit    = 1'b1;
                fwd_target = w_mem[w_slot].target;
                fwd_taken  = w_mem[w_slot].taken;
            end
        end
    end
`else
    assign fwd_hit    = 1'b0;
    assign fwd_target = '0;
    assign fwd_taken  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_ctrl
// Brief    : Self-checking bench for btb_update_ctrl: directed scenarios plus
//            a randomized run against a queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;
    import cpu_types_pkg::*;

    localparam int QDEPTH     = 4;
    localparam int IDX_W      = 2;
    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        fetch_req = 1'b0;
    logic [1:0]  fetch_index = '0;
    logic        res_valid = 1'b0;
    logic [1:0]  res_index = '0;
    logic [31:0] res_target = '0;
    logic        res_taken = 1'b0;
    logic        fetch_stall, res_ready, btb_ren, btb_wen, btb_wtaken, fwd_hit, fwd_taken;
    logic [1:0]  btb_rindex, btb_windex;
    logic [31:0] btb_wtarget, fwd_target;
    logic [2:0]  qcount;

    int n_checks = 0;
    int n_errors = 0;

    btb_update_ctrl #(
        .QDEPTH(QDEPTH), .IDX_W(IDX_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_stall(fetch_stall),
        .res_valid(res_valid), .res_index(res_index), .res_target(res_target),
        .res_taken(res_taken), .res_ready(res_ready),
        .btb_ren(btb_ren), .btb_rindex(btb_rindex),
        .btb_wen(btb_wen), .btb_windex(btb_windex), .btb_wtarget(btb_wtarget),
        .btb_wtaken(btb_wtaken),
        .fwd_hit(fwd_hit), .fwd_target(fwd_target), .fwd_taken(fwd_taken),
        .qcount(qcount)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic fr, input logic [1:0] fi, input logic rv,
                         input logic [1:0] ri, input logic [31:0] rt, input logic rk);
        fetch_req   = fr;
        fetch_index = fi;
        res_valid   = rv;
        res_index   = ri;
        res_target  = rt;
        res_taken   = rk;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({fetch_stall, btb_ren, btb_wen, res_ready, fwd_hit, qcount} !== 8'b0) begin
            n_errors++; $display("FAIL reset_init: got ctl=%b want 0", {fetch_stall, btb_ren, btb_wen, res_ready, fwd_hit, qcount});
        end
        @(negedge CLK); RST = 1'b0; drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK); #1;
        n_checks++;
        if (res_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %b want 1", res_ready); end
        @(negedge CLK); drive(1, 0, 1, 3, 32'hAA, 1);
        @(negedge CLK); drive(1, 0, 1, 2, 32'hBB, 0);
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
        n_checks++;
        if (btb_wen !== 1'b1 || qcount !== 3'd2) begin
            n_errors++; $display("FAIL reset_predrain: got wen=%b cnt=%0d want 1/2", btb_wen, qcount);
        end
        RST = 1'b1; fetch_req = 1'b1; res_valid = 1'b1; #1;
        n_checks++;
        if ({fetch_stall, btb_ren, btb_wen, res_ready, fwd_hit, fwd_taken, btb_wtaken} !== 7'b0) begin
            n_errors++; $display("FAIL reset_async_ctl: got %b want 0000000", {fetch_stall, btb_ren, btb_wen, res_ready, fwd_hit, fwd_taken, btb_wtaken});
        end
        n_checks++;
        if (qcount !== 3'd0 || btb_windex !== 2'd0 || btb_wtarget !== 32'd0 || fwd_target !== 32'd0) begin
            n_errors++; $display("FAIL reset_async_data: got cnt=%0d widx=%0d wtgt=%h ftgt=%h want 0", qcount, btb_windex, btb_wtarget, fwd_target);
        end
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
        n_checks++;
        if (res_ready !== 1'b0 || btb_wen !== 1'b0) begin
            n_errors++; $display("FAIL reset_hold: got rdy=%b wen=%b want 0/0", res_ready, btb_wen);
        end
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); #1;
        n_checks++;
        if (res_ready !== 1'b1 || qcount !== 3'd0 || btb_wen !== 1'b0) begin
            n_errors++; $display("FAIL reset_discard: got rdy=%b cnt=%0d wen=%b want 1/0/0", res_ready, qcount, btb_wen);
        end
    endtask

    task automatic test_idle_drain;
        @(negedge CLK); drive(0, 0, 1, 1, 32'h40, 1); #1;
        n_checks++;
        if (btb_wen !== 1'b0 || res_ready !== 1'b1) begin
            n_errors++; $display("FAIL idle_push: got wen=%b rdy=%b want 0/1", btb_wen, res_ready);
        end
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
        n_checks++;
        if (btb_wen !== 1'b1 || btb_windex !== 2'd1 || btb_wtarget !== 32'h40 || btb_wtaken !== 1'b1 || qcount !== 3'd1) begin
            n_errors++; $display("FAIL idle_write: got wen=%b idx=%0d tgt=%h tk=%b cnt=%0d want 1/1/40/1/1", btb_wen, btb_windex, btb_wtarget, btb_wtaken, qcount);
        end
        @(negedge CLK); #1;
        n_checks++;
        if (btb_wen !== 1'b0 || qcount !== 3'd0) begin
            n_errors++; $display("FAIL idle_after: got wen=%b cnt=%0d want 0/0", btb_wen, qcount);
        end
    endtask

    task automatic test_starvation;
        @(negedge CLK); drive(1, 3, 1, 0, 32'h80, 0);
        for (int c = 0; c < STARVE_MAX; c++) begin
            @(negedge CLK); drive(1, 3, 0, 0, 0, 0); #1;
            n_checks++;
            if (btb_wen !== 1'b0 || btb_ren !== 1'b1 || fetch_stall !== 1'b0) begin
                n_errors++; $display("FAIL starve_wait%0d: got wen=%b ren=%b stall=%b want 0/1/0", c, btb_wen, btb_ren, fetch_stall);
            end
        end
        @(negedge CLK); #1;
        n_checks++;
        if (fetch_stall !== 1'b1 || btb_ren !== 1'b0 || btb_wen !== 1'b1 || btb_wtarget !== 32'h80) begin
            n_errors++; $display("FAIL starve_force: got stall=%b ren=%b wen=%b tgt=%h want 1/0/1/80", fetch_stall, btb_ren, btb_wen, btb_wtarget);
        end
        @(negedge CLK); #1;
        n_checks++;
        if (fetch_stall !== 1'b0 || btb_ren !== 1'b1 || btb_wen !== 1'b0 || qcount !== 3'd0) begin
            n_errors++; $display("FAIL starve_idle: got stall=%b ren=%b wen=%b cnt=%0d want 0/1/0/0", fetch_stall, btb_ren, btb_wen, qcount);
        end
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full;
        logic [31:0] exp_tgt [3];
        exp_tgt[0] = 32'hA3; exp_tgt[1] = 32'hA4; exp_tgt[2] = 32'hA6;
        @(negedge CLK); drive(1, 0, 1, 0, 32'hA1, 1);
        @(negedge CLK); drive(1, 0, 1, 1, 32'hA2, 0);
        @(negedge CLK); drive(1, 0, 1, 2, 32'hA3, 1);
        @(negedge CLK); drive(1, 0, 1, 3, 32'hA4, 0);
        @(negedge CLK); drive(1, 0, 1, 0, 32'hE5, 1); #1;
        n_checks++;
        if (res_ready !== 1'b0 || qcount !== 3'd4 || btb_wen !== 1'b1 || fetch_stall !== 1'b1) begin
            n_errors++; $display("FAIL full_force: got rdy=%b cnt=%0d wen=%b stall=%b want 0/4/1/1", res_ready, qcount, btb_wen, fetch_stall);
        end
        @(negedge CLK); drive(1, 0, 1, 1, 32'hA6, 1); #1;
        n_checks++;
        if (res_ready !== 1'b1 || qcount !== 3'd3) begin
            n_errors++; $display("FAIL full_reopen: got rdy=%b cnt=%0d want 1/3", res_ready, qcount);
        end
        @(negedge CLK); drive(1, 0, 1, 2, 32'hE7, 0); #1;
        n_checks++;
        if (res_ready !== 1'b0 || qcount !== 3'd4 || btb_wen !== 1'b0) begin
            n_errors++; $display("FAIL full_block: got rdy=%b cnt=%0d wen=%b want 0/4/0", res_ready, qcount, btb_wen);
        end
        @(negedge CLK); drive(1, 0, 1, 3, 32'hE8, 0); #1;
        n_checks++;
        if (res_ready !== 1'b0 || qcount !== 3'd4) begin
            n_errors++; $display("FAIL full_drop: got rdy=%b cnt=%0d want 0/4", res_ready, qcount);
        end
        @(negedge CLK); drive(1, 0, 1, 0, 32'hE9, 0); #1;
        n_checks++;
        if (res_ready !== 1'b0 || btb_wen !== 1'b1) begin
            n_errors++; $display("FAIL full_pushpop: got rdy=%b wen=%b want 0/1", res_ready, btb_wen);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
            n_checks++;
            if (btb_wen !== 1'b1 || btb_wtarget !== exp_tgt[i]) begin
                n_errors++; $display("FAIL full_drain%0d: got wen=%b tgt=%h want 1/%h", i, btb_wen, btb_wtarget, exp_tgt[i]);
            end
        end
        @(negedge CLK); #1;
        n_checks++;
        if (btb_wen !== 1'b0 || qcount !== 3'd0) begin
            n_errors++; $display("FAIL full_empty: got wen=%b cnt=%0d want 0/0", btb_wen, qcount);
        end
    endtask

    task automatic test_order_wrap;
        logic [31:0] exp_q [$];
        int pushed  = 0;
        int written = 0;
        for (int c = 0; c < 40 && written < 6; c++) begin
            @(negedge CLK);
            drive((c % 3) == 1, 0, pushed < 6, 2'(c), 32'h10 * (pushed + 1), 1'(c));
            #1;
            if (btb_wen === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0 || btb_wtarget !== exp_q[0]) begin
                    n_errors++; $display("FAIL order_write%0d: got %h want %h", written, btb_wtarget, (exp_q.size() > 0) ? exp_q[0] : 32'hX);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                written++;
            end
            if (res_valid && res_ready) begin
                exp_q.push_back(res_target);
                pushed++;
            end
        end
        n_checks++;
        if (written != 6) begin n_errors++; $display("FAIL order_count: got %0d writes want 6", written); end
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_bypass;
        logic        e_hit;
        logic [31:0] e_tgt;
        logic        e_tk;
`ifdef BTB_UPD_BYPASS_EN
        e_hit = 1'b1; e_tgt = 32'h200; e_tk = 1'b1;
`else
        e_hit = 1'b0; e_tgt = 32'h0; e_tk = 1'b0;
`endif
        @(negedge CLK); drive(1, 2, 1, 2, 32'h100, 0);
        @(negedge CLK); drive(1, 2, 1, 2, 32'h200, 1);
        @(negedge CLK); drive(1, 2, 0, 0, 0, 0); #1;
        n_checks++;
        if (fwd_hit !== e_hit || fwd_target !== e_tgt || fwd_taken !== e_tk) begin
            n_errors++; $display("FAIL bypass_hit: got %b/%h/%b want %b/%h/%b", fwd_hit, fwd_target, fwd_taken, e_hit, e_tgt, e_tk);
        end
        fetch_index = 2'd1; #1;
        n_checks++;
        if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL bypass_miss: got %b want 0", fwd_hit); end
        @(negedge CLK); drive(0, 2, 0, 0, 0, 0); #1;
        n_checks++;
        if (fwd_hit !== 1'b0 || btb_wtarget !== 32'h100) begin
            n_errors++; $display("FAIL bypass_nofetch: got hit=%b wtgt=%h want 0/100", fwd_hit, btb_wtarget);
        end
        @(negedge CLK);
        @(negedge CLK); #1;
        n_checks++;
        if (qcount !== 3'd0) begin n_errors++; $display("FAIL bypass_empty: got cnt=%0d want 0", qcount); end
    endtask

    task automatic test_random;
        ent_t mq [$];
        int   starve = 0;
        bit   frc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        e_wen, e_ready, e_hit, e_tk;
            logic [31:0] e_tgt;
            @(negedge CLK);
            drive($urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 9) < 6,
                  2'($urandom), $urandom, 1'($urandom));
            e_ready = (mq.size() < QDEPTH);
            e_wen   = (mq.size() > 0) && (frc || !fetch_req);
            e_hit = 1'b0; e_tgt = '0; e_tk = 1'b0;
`ifdef BTB_UPD_BYPASS_EN
            if (fetch_req) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == fetch_index) begin
                        e_hit = 1'b1; e_tgt = mq[i].tgt; e_tk = mq[i].tk;
                    end
                end
            end
`endif
            #1;
            n_checks++;
            if (btb_wen !== e_wen) begin n_errors++; $display("FAIL rnd_wen c%0d: got %b want %b", c, btb_wen, e_wen); end
            n_checks++;
            if (btb_ren !== (fetch_req && !frc) || fetch_stall !== frc) begin
                n_errors++; $display("FAIL rnd_port c%0d: got ren=%b stall=%b want %b/%b", c, btb_ren, fetch_stall, fetch_req && !frc, frc);
            end
            n_checks++;
            if (res_ready !== e_ready || qcount !== 3'(mq.size())) begin
                n_errors++; $display("FAIL rnd_queue c%0d: got rdy=%b cnt=%0d want %b/%0d", c, res_ready, qcount, e_ready, mq.size());
            end
            if (mq.size() > 0) begin
                n_checks++;
                if ({btb_windex, btb_wtarget, btb_wtaken} !== {mq[0].idx, mq[0].tgt, mq[0].tk}) begin
                    n_errors++; $display("FAIL rnd_head c%0d: got %0d/%h/%b want %0d/%h/%b", c, btb_windex, btb_wtarget, btb_wtaken, mq[0].idx, mq[0].tgt, mq[0].tk);
                end
            end
            n_checks++;
            if (fwd_hit !== e_hit || fwd_target !== e_tgt || fwd_taken !== e_tk) begin
                n_errors++; $display("FAIL rnd_fwd c%0d: got %b/%h/%b want %b/%h/%b", c, fwd_hit, fwd_target, fwd_taken, e_hit, e_tgt, e_tk);
            end
            // Advance the model across the coming clock edge.
            if (e_wen) begin
                void'(mq.pop_front());
                starve = 0;
                frc    = 1'b0;
            end else if (mq.size() > 0 && fetch_req) begin
                if (starve < STARVE_MAX) starve++;
                frc = (starve == STARVE_MAX);
            end else begin
                starve = 0;
                frc    = 1'b0;
            end
            if (res_valid && e_ready) mq.push_back('{idx: res_index, tgt: res_target, tk: res_taken});
        end
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 RST = 1'b1;
        #2;
        test_reset();
        test_idle_drain();
        test_starvation();
        test_full();
        test_order_wrap();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameters SHALL be:
- QDEPTH, default 4: update queue depth, power of two.
- IDX_W, default 2: BTB index width.
- STARVE_MAX, default 3: blocked-write cycles before a forced write.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  fetch wants a BTB lookup this cycle.
- fetch_index  in  IDX_W  lookup index.
- fetch_stall  out  1  fetch held this cycle; BTB port is taken by a write.
- res_valid  in  1  resolved-branch update offered.
- res_index  in  IDX_W  update index.
- res_target  in  word_t  resolved target.
- res_taken  in  1  resolved direction.
- res_ready  out  1  queue can accept an update.
- btb_ren  out  1  BTB read strobe.
- btb_rindex  out  IDX_W  BTB read index.
- btb_wen  out  1  BTB write strobe.
- btb_windex  out  IDX_W  BTB write index.
- btb_wtarget  out  word_t  BTB write target.
- btb_wtaken  out  1  BTB write direction.
- fwd_hit  out  1  lookup matched a pending queued update.
- fwd_target  out  word_t  forwarded target.
- fwd_taken  out  1  forwarded direction.
- qcount  out  $clog2(QDEPTH)+1  queue occupancy.

Function
REQ-003 The block SHALL arbitrate the single BTB port so that btb_ren and btb_wen are never both 1 in the same cycle.
REQ-004 btb_ren SHALL equal fetch_req && !fetch_stall, and btb_rindex SHALL equal fetch_index, both combinationally.
REQ-005 A push SHALL occur on a rising edge when res_valid && res_ready; res_valid while res_ready=0 SHALL be dropped and leave state unchanged.
REQ-006 res_ready SHALL equal (qcount != QDEPTH) from registered state only; a pop in the same cycle SHALL NOT raise it.
REQ-007 btb_windex, btb_wtarget and btb_wtaken SHALL always present the queue head; each cycle with btb_wen=1 SHALL pop the head.
REQ-008 A push and a pop in the same cycle SHALL leave qcount unchanged and keep FIFO order.
REQ-009 The FSM states SHALL be IDLE (queue empty), DRAIN (queue non-empty) and FORCE.
REQ-010 IDLE SHALL go to DRAIN on a push; it SHALL assert neither btb_wen nor fetch_stall.
REQ-011 In DRAIN with fetch_req=0: btb_wen=1. The next state SHALL be IDLE if the post-pop count is 0, else DRAIN.
REQ-012 In DRAIN with fetch_req=1: btb_wen=0, and the starve counter SHALL increment, saturating at STARVE_MAX. The next state SHALL be FORCE when the incremented value equals STARVE_MAX.
REQ-013 In FORCE: fetch_stall=1, btb_ren=0, btb_wen=1 with a pop. The next state SHALL be DRAIN if the post-pop count is above 0, else IDLE.
REQ-014 The starve counter SHALL clear on every cycle with btb_wen=1 and in IDLE.
REQ-015 Write latency SHALL be: a push into an empty queue with fetch_req=0 reaches btb_wen exactly one cycle later.
REQ-016 Read and write pointers SHALL wrap modulo QDEPTH.

Reset
REQ-017 While RST=1, and asynchronously on its assertion:
- state SHALL be IDLE;
- pointers, qcount and the starve counter SHALL be 0;
- fetch_stall, btb_ren, btb_wen, res_ready and fwd_hit SHALL be 0;
- btb_windex, btb_wtarget, btb_wtaken, fwd_target and fwd_taken SHALL be 0.
REQ-018 Reset mid-drain SHALL discard all queued updates without a partial write.
REQ-019 On the first edge after RST deasserts, res_ready SHALL be 1.

Configuration
REQ-020 With BTB_UPD_BYPASS_EN defined: when fetch_req=1 and any valid queued entry index equals fetch_index, fwd_hit=1 and fwd_target/fwd_taken SHALL come from the youngest matching entry, combinationally. An entry being popped that cycle still SHALL match.
REQ-021 Without BTB_UPD_BYPASS_EN: fwd_hit, fwd_target and fwd_taken SHALL be tied to 0, and no compare logic SHALL exist.

Structure
REQ-022 cpu_types_pkg SHALL hold btb_upd_t (index, target, taken) and the btb_ctrl_state_t enum (IDLE, DRAIN, FORCE).
REQ-023 Queue storage and pointers SHALL live in the sub-module btb_upd_fifo; the FSM, arbitration and bypass SHALL live in btb_update_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset: RST=1 mid-operation -> all outputs 0 immediately; res_ready=1 one edge after release.
- Idle drain: push (index 1, 0x00000040, taken) with fetch_req=0 -> next cycle btb_wen=1, btb_windex=1, btb_wtarget=0x00000040; qcount goes 1 -> 0.
- Starvation: one entry queued, fetch_req=1 held -> btb_wen=0 for 3 cycles, then FORCE: fetch_stall=1, btb_ren=0, btb_wen=1; state then IDLE.
- Full: 4 pushes with fetch_req=1 -> res_ready=0; a 5th push is dropped and qcount stays 4; pushing while a pop occurs keeps res_ready=0 that cycle.
- Order and wrap: 6 pushes (targets 0x10..0x60) interleaved with drains -> writes appear in push order across pointer wrap.
- Bypass (macro on): entries index 2 targets 0x100 then 0x200, lookup fetch_index=2 -> fwd_hit=1, fwd_target=0x200; macro off -> fwd_hit=0.
